// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared decode types: opcodes, control bundle, skid-buffer FSM states.
// Imported by instr_ctrl_decode and decode_ctrl_pipe.
package cpu_consts;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   // {alt, funct3} so R/I ops map directly
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_e;

   typedef enum logic [1:0] {
      OPA_RS1, OPA_PC, OPA_ZERO
   } opa_sel_e;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_sel_e;

   typedef enum logic [1:0] {
      WB_ALU, WB_MEM, WB_PC4, WB_MD
   } wb_src_e;

   typedef enum logic [1:0] {
      PC_SEQ, PC_BR, PC_JAL, PC_JALR
   } pc_sel_e;

   typedef struct packed {
      alu_op_e     alu_op;
      opa_sel_e    opa_sel;
      logic        opb_imm;
      imm_sel_e    imm_sel;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rf_wr_en;
      wb_src_e     rf_wr_data_src;
      logic        data_req;
      logic        data_we;
      logic [1:0]  data_size;
      logic        data_uns;
      pc_sel_e     pc_sel;
      logic [2:0]  br_op;
      logic        md_req;
      logic [2:0]  md_op;
   } control_t;

   typedef enum logic [1:0] {
      EMPTY, ONE, TWO
   } skid_state_t;

   function automatic logic [31:0] imm_gen(
      input logic [31:0] i,
      input imm_sel_e    s
   );
      logic [31:0] r;
      r = '0;
      unique case (s)
         IMM_I: r = {{20{i[31]}}, i[31:20]};
         IMM_S: r = {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B: r = {{19{i[31]}}, i[31], i[7],
                     i[30:25], i[11:8], 1'b0};
         IMM_U: r = {i[31:12], 12'b0};
         IMM_J: r = {{11{i[31]}}, i[31], i[19:12],
                     i[20], i[30:21], 1'b0};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/instr_ctrl_decode.sv
// Combinational RV32I(+M) decoder: instr_i -> ctrl_o, illegal_o.
// Illegal encodings return an all-zero control bundle.
module instr_ctrl_decode
   import cpu_consts::*;
#(
   parameter bit EN_MEXT = 1'b1
) (
   input  logic [31:0] instr_i,
   output control_t    ctrl_o,
   output logic        illegal_o
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   control_t   c;
   logic       ill;

   assign opc = instr_i[6:0];
   assign f3  = instr_i[14:12];
   assign f7  = instr_i[31:25];

   always_comb begin
      c     = '0;
      ill   = 1'b0;
      c.rd  = instr_i[11:7];
      c.rs1 = instr_i[19:15];
      c.rs2 = instr_i[24:20];
      unique case (opc)
         OPC_LUI: begin
            c.opa_sel  = OPA_ZERO;
            c.opb_imm  = 1'b1;
            c.imm_sel  = IMM_U;
            c.rf_wr_en = 1'b1;
         end
         OPC_AUIPC: begin
            c.opa_sel  = OPA_PC;
            c.opb_imm  = 1'b1;
            c.imm_sel  = IMM_U;
            c.rf_wr_en = 1'b1;
         end
         OPC_JAL: begin
            c.opa_sel        = OPA_PC;
            c.opb_imm        = 1'b1;
            c.imm_sel        = IMM_J;
            c.rf_wr_en       = 1'b1;
            c.rf_wr_data_src = WB_PC4;
            c.pc_sel         = PC_JAL;
         end
         OPC_JALR: begin
            ill              = (f3 != 3'd0);
            c.opb_imm        = 1'b1;
            c.imm_sel        = IMM_I;
            c.rf_wr_en       = 1'b1;
            c.rf_wr_data_src = WB_PC4;
            c.pc_sel         = PC_JALR;
         end
         OPC_BRANCH: begin
            ill       = (f3 == 3'd2) || (f3 == 3'd3);
            c.opa_sel = OPA_PC;
            c.opb_imm = 1'b1;
            c.imm_sel = IMM_B;
            c.pc_sel  = PC_BR;
            c.br_op   = f3;
         end
         OPC_LOAD: begin
            ill              = (f3 == 3'd3) || (f3 > 3'd5);
            c.opb_imm        = 1'b1;
            c.imm_sel        = IMM_I;
            c.rf_wr_en       = 1'b1;
            c.rf_wr_data_src = WB_MEM;
            c.data_req       = 1'b1;
            c.data_size      = f3[1:0];
            c.data_uns       = f3[2];
         end
         OPC_STORE: begin
            ill         = (f3 > 3'd2);
            c.opb_imm   = 1'b1;
            c.imm_sel   = IMM_S;
            c.data_req  = 1'b1;
            c.data_we   = 1'b1;
            c.data_size = f3[1:0];
         end
         OPC_OPIMM: begin
            c.opb_imm  = 1'b1;
            c.imm_sel  = IMM_I;
            c.rf_wr_en = 1'b1;
            c.alu_op   = alu_op_e'({1'b0, f3});
            // shift-immediates reuse funct7 as a qualifier
            if (f3 == 3'd1) begin
               ill = (f7 != F7_BASE);
            end else if (f3 == 3'd5) begin
               if (f7 == F7_ALT) c.alu_op = ALU_SRA;
               else ill = (f7 != F7_BASE);
            end
         end
         OPC_OP: begin
            c.rf_wr_en = 1'b1;
            if (f7 == F7_BASE) begin
               c.alu_op = alu_op_e'({1'b0, f3});
            end else if (f7 == F7_ALT &&
                         (f3 == 3'd0 || f3 == 3'd5)) begin
               c.alu_op = alu_op_e'({1'b1, f3});
            end else if (f7 == F7_MEXT && EN_MEXT) begin
               c.md_req         = 1'b1;
               c.md_op          = f3;
               c.rf_wr_data_src = WB_MD;
            end else begin
               ill = 1'b1;
            end
         end
         default: ill = 1'b1;
      endcase
      c.imm = imm_gen(instr_i, c.imm_sel);
      if (c.rd == 5'd0) c.rf_wr_en = 1'b0;
      if (ill) c = '0;
   end

   assign ctrl_o    = c;
   assign illegal_o = ill;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode stage with 2-entry skid buffer, flush and issue counter.
// In: instr/pc valid-ready from fetch. Out: ctrl/pc/illegal to execute.
module decode_ctrl_pipe
   import cpu_consts::*;
#(
   parameter int XLEN    = 32,
   parameter bit EN_MEXT = 1'b1,
   parameter int CNT_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       instr_valid_i,
   output logic                       instr_ready_o,
   input  logic [31:0]                instr_i,
   input  logic [XLEN-1:0]            pc_i,
   output logic                       ctrl_valid_o,
   input  logic                       ctrl_ready_i,
   output logic [$bits(control_t)-1:0] ctrl_o,
   output logic [XLEN-1:0]            pc_o,
   output logic                       illegal_o,
   output logic [CNT_W-1:0]           decode_cnt_o
);

   control_t    dec_ctrl;
   logic        dec_ill;

   skid_state_t state_q, state_d;
   logic        rdy_q, rdy_d;
   control_t    hc_q, hc_d, sc_q, sc_d;
   logic [XLEN-1:0] hp_q, hp_d, sp_q, sp_d;
   logic        hi_q, hi_d, si_q, si_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        accept, issue;

   instr_ctrl_decode #(.EN_MEXT(EN_MEXT)) u_dec (
      .instr_i   (instr_i),
      .ctrl_o    (dec_ctrl),
      .illegal_o (dec_ill)
   );

   assign ctrl_valid_o  = (state_q != EMPTY);
   assign instr_ready_o = rdy_q;
   assign accept        = instr_valid_i & rdy_q;
   assign issue         = ctrl_valid_o & ctrl_ready_i;

   always_comb begin
      state_d = state_q;
      hc_d    = hc_q;
      hp_d    = hp_q;
      hi_d    = hi_q;
      sc_d    = sc_q;
      sp_d    = sp_q;
      si_d    = si_q;
      cnt_d   = cnt_q + CNT_W'(issue);
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               hc_d = dec_ctrl;
               hp_d = pc_i;
               hi_d = dec_ill;
            end
         end
         ONE: begin
            if (accept && issue) begin
               hc_d = dec_ctrl;
               hp_d = pc_i;
               hi_d = dec_ill;
            end else if (accept) begin
               state_d = TWO;
               sc_d = dec_ctrl;
               sp_d = pc_i;
               si_d = dec_ill;
            end else if (issue) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // ready is low here, so only a drain can happen
            if (issue) begin
               state_d = ONE;
               hc_d = sc_q;
               hp_d = sp_q;
               hi_d = si_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush_i) state_d = EMPTY;
      rdy_d = (state_d != TWO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         rdy_q   <= 1'b1;
         hc_q    <= '0;
         hp_q    <= '0;
         hi_q    <= 1'b0;
         sc_q    <= '0;
         sp_q    <= '0;
         si_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         hc_q    <= hc_d;
         hp_q    <= hp_d;
         hi_q    <= hi_d;
         sc_q    <= sc_d;
         sp_q    <= sp_d;
         si_q    <= si_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ctrl_o       = hc_q;
   assign pc_o         = hp_q;
   assign illegal_o    = hi_q;
   assign decode_cnt_o = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe.
// dut0: EN_MEXT=1, CNT_W=32. dut1: EN_MEXT=0, CNT_W=4.
module tb_decode_ctrl_pipe;
   import cpu_consts::*;

   localparam int CW = $bits(control_t);
   localparam logic [31:0] I_ADD  = 32'h003100B3;
   localparam logic [31:0] I_ADDI = 32'hFFF08213;
   localparam logic [31:0] I_LW   = 32'h00812303;
   localparam logic [31:0] I_MUL  = 32'h027302B3;
   localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
   localparam logic [31:0] I_NOP1 = 32'h00100013;
   localparam logic [31:0] I_LW0  = 32'h00002003;

   logic clk = 1'b0;
   logic rst, flush, valid, crdy;
   logic [31:0] instr, pc;
   logic r0, v0, ill0, r1, v1, ill1;
   logic [CW-1:0] ctrl0, ctrl1;
   logic [31:0] pc0, pc1, cnt0;
   logic [3:0] cnt1;
   control_t c0;
   int checks = 0;
   int fails = 0;

   assign c0 = ctrl0;

   always #5 clk = ~clk;

   decode_ctrl_pipe #(.XLEN(32), .EN_MEXT(1'b1), .CNT_W(32)) dut0 (
      .clk(clk), .rst(rst), .flush_i(flush),
      .instr_valid_i(valid), .instr_ready_o(r0),
      .instr_i(instr), .pc_i(pc),
      .ctrl_valid_o(v0), .ctrl_ready_i(crdy),
      .ctrl_o(ctrl0), .pc_o(pc0), .illegal_o(ill0),
      .decode_cnt_o(cnt0)
   );

   decode_ctrl_pipe #(.XLEN(32), .EN_MEXT(1'b0), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .flush_i(flush),
      .instr_valid_i(valid), .instr_ready_o(r1),
      .instr_i(instr), .pc_i(pc),
      .ctrl_valid_o(v1), .ctrl_ready_i(crdy),
      .ctrl_o(ctrl1), .pc_o(pc1), .illegal_o(ill1),
      .decode_cnt_o(cnt1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 1'b0; valid = 1'b0; crdy = 1'b0;
      instr = '0; pc = '0;
      tick; tick;
      checks++;
      if ({v0, r0, ill0} !== 3'b010) begin
         fails++;
         $display("FAIL reset_flags0 got=%b exp=010", {v0, r0, ill0});
      end
      checks++;
      if ({ctrl0, pc0, cnt0} !== '0) begin
         fails++;
         $display("FAIL reset_data0 got ctrl=%h pc=%h cnt=%h exp=0",
                  ctrl0, pc0, cnt0);
      end
      checks++;
      if ({v1, r1, ill1, ctrl1, pc1, cnt1} !==
          {1'b0, 1'b1, 1'b0, {(CW + 36){1'b0}}}) begin
         fails++;
         $display("FAIL reset_dut1 got v=%b r=%b cnt=%h exp v=0 r=1 cnt=0",
                  v1, r1, cnt1);
      end
      rst = 1'b0;
   endtask

   task automatic test_stream;
      crdy = 1'b1; valid = 1'b1; instr = I_ADD; pc = 32'h100;
      tick;
      checks++;
      if ({v0, pc0, cnt0} !== {1'b1, 32'h100, 32'd0}) begin
         fails++;
         $display("FAIL stream_add_hdr got v=%b pc=%h cnt=%0d exp v=1 pc=100 cnt=0",
                  v0, pc0, cnt0);
      end
      checks++;
      if ({c0.alu_op, c0.rd, c0.rs1, c0.rs2, c0.rf_wr_en, c0.opb_imm}
          !== {ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL stream_add_ctrl got alu=%h rd=%0d rs1=%0d rs2=%0d",
                  c0.alu_op, c0.rd, c0.rs1, c0.rs2);
      end
      instr = I_ADDI; pc = 32'h104;
      tick;
      checks++;
      if ({pc0, cnt0, c0.imm, c0.rd, c0.rs1, c0.opb_imm, c0.rf_wr_en}
          !== {32'h104, 32'd1, 32'hFFFFFFFF, 5'd4, 5'd1, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL stream_addi got pc=%h cnt=%0d imm=%h rd=%0d",
                  pc0, cnt0, c0.imm, c0.rd);
      end
      instr = I_LW; pc = 32'h108;
      tick;
      checks++;
      if ({c0.data_req, c0.data_we, c0.data_size, c0.data_uns,
           c0.rf_wr_data_src, c0.rd, c0.imm, cnt0}
          !== {1'b1, 1'b0, 2'd2, 1'b0, WB_MEM, 5'd6, 32'd8, 32'd2}) begin
         fails++;
         $display("FAIL stream_lw got req=%b size=%0d src=%0d rd=%0d cnt=%0d",
                  c0.data_req, c0.data_size, c0.rf_wr_data_src, c0.rd, cnt0);
      end
      valid = 1'b0;
      tick;
      checks++;
      if ({v0, r0, cnt0} !== {1'b0, 1'b1, 32'd3}) begin
         fails++;
         $display("FAIL stream_end got v=%b r=%b cnt=%0d exp v=0 r=1 cnt=3",
                  v0, r0, cnt0);
      end
   endtask

   task automatic test_stall;
      crdy = 1'b0; valid = 1'b1; instr = I_ADD; pc = 32'h200;
      tick;
      checks++;
      if ({v0, r0, pc0} !== {1'b1, 1'b1, 32'h200}) begin
         fails++;
         $display("FAIL stall_first got v=%b r=%b pc=%h exp 1 1 200",
                  v0, r0, pc0);
      end
      instr = I_ADDI; pc = 32'h204;
      tick;
      checks++;
      if ({r0, pc0} !== {1'b0, 32'h200}) begin
         fails++;
         $display("FAIL stall_full got r=%b pc=%h exp r=0 pc=200", r0, pc0);
      end
      instr = I_LW; pc = 32'h208;
      tick;
      checks++;
      if ({v0, r0, pc0, c0.rd} !== {1'b1, 1'b0, 32'h200, 5'd1}) begin
         fails++;
         $display("FAIL stall_hold got v=%b r=%b pc=%h rd=%0d exp 1 0 200 1",
                  v0, r0, pc0, c0.rd);
      end
      valid = 1'b0; crdy = 1'b1;
      tick;
      checks++;
      if ({v0, r0, pc0, c0.rd} !== {1'b1, 1'b1, 32'h204, 5'd4}) begin
         fails++;
         $display("FAIL stall_drain got v=%b r=%b pc=%h rd=%0d exp 1 1 204 4",
                  v0, r0, pc0, c0.rd);
      end
      tick;
      checks++;
      if ({v0, cnt0} !== {1'b0, 32'd5}) begin
         fails++;
         $display("FAIL stall_end got v=%b cnt=%0d exp v=0 cnt=5", v0, cnt0);
      end
   endtask

   task automatic test_mext_illegal;
      crdy = 1'b1; valid = 1'b1; instr = I_MUL; pc = 32'h300;
      tick;
      checks++;
      if ({ill0, c0.md_req, c0.md_op, c0.rf_wr_data_src, c0.rf_wr_en, c0.rd}
          !== {1'b0, 1'b1, 3'd0, WB_MD, 1'b1, 5'd5}) begin
         fails++;
         $display("FAIL mul_en got ill=%b md=%b op=%0d src=%0d rd=%0d",
                  ill0, c0.md_req, c0.md_op, c0.rf_wr_data_src, c0.rd);
      end
      checks++;
      if ({ill1, ctrl1} !== {1'b1, {CW{1'b0}}}) begin
         fails++;
         $display("FAIL mul_dis got ill=%b ctrl=%h exp ill=1 ctrl=0",
                  ill1, ctrl1);
      end
      instr = I_BAD;
      tick;
      checks++;
      if ({ill0, ctrl0} !== {1'b1, {CW{1'b0}}}) begin
         fails++;
         $display("FAIL ill_ffff got ill=%b ctrl=%h exp ill=1 ctrl=0",
                  ill0, ctrl0);
      end
      instr = I_NOP1;
      tick;
      checks++;
      if ({ill0, c0.rf_wr_en, c0.imm} !== {1'b0, 1'b0, 32'd1}) begin
         fails++;
         $display("FAIL addi_x0 got ill=%b wr=%b imm=%h exp 0 0 1",
                  ill0, c0.rf_wr_en, c0.imm);
      end
      instr = I_LW0;
      tick;
      checks++;
      if ({ill0, c0.rf_wr_en, c0.data_req} !== 3'b001) begin
         fails++;
         $display("FAIL lw_x0 got ill=%b wr=%b req=%b exp 0 0 1",
                  ill0, c0.rf_wr_en, c0.data_req);
      end
      valid = 1'b0;
      tick;
      checks++;
      if (cnt0 !== 32'd9) begin
         fails++;
         $display("FAIL mext_cnt got=%0d exp=9", cnt0);
      end
   endtask

   task automatic test_flush;
      crdy = 1'b0; valid = 1'b1; instr = I_ADD; pc = 32'h400;
      tick;
      instr = I_ADDI; pc = 32'h404;
      tick;
      flush = 1'b1; instr = I_LW; pc = 32'h408;
      tick;
      checks++;
      if ({v0, r0} !== 2'b01) begin
         fails++;
         $display("FAIL flush_two got v=%b r=%b exp v=0 r=1", v0, r0);
      end
      flush = 1'b0; valid = 1'b0; crdy = 1'b1;
      tick;
      checks++;
      if ({v0, cnt0} !== {1'b0, 32'd9}) begin
         fails++;
         $display("FAIL flush_two_after got v=%b cnt=%0d exp 0 9", v0, cnt0);
      end
      valid = 1'b1; instr = I_ADD; pc = 32'h500;
      tick;
      flush = 1'b1; instr = I_ADDI; pc = 32'h504;
      tick;
      checks++;
      if ({v0, r0, cnt0} !== {1'b0, 1'b1, 32'd10}) begin
         fails++;
         $display("FAIL flush_one got v=%b r=%b cnt=%0d exp 0 1 10",
                  v0, r0, cnt0);
      end
      flush = 1'b0; valid = 1'b0;
      tick;
      checks++;
      if ({v0, cnt0} !== {1'b0, 32'd10}) begin
         fails++;
         $display("FAIL flush_one_after got v=%b cnt=%0d exp 0 10", v0, cnt0);
      end
   endtask

   task automatic test_reset_wrap;
      crdy = 1'b0; valid = 1'b1; instr = I_ADD; pc = 32'h600;
      tick;
      pc = 32'h604;
      tick;
      rst = 1'b1;
      tick;
      checks++;
      if ({v0, r0, ill0, ctrl0, pc0, cnt0, cnt1} !==
          {1'b0, 1'b1, 1'b0, {(CW + 68){1'b0}}}) begin
         fails++;
         $display("FAIL rst_stall got v=%b r=%b pc=%h cnt=%0d cnt1=%0d",
                  v0, r0, pc0, cnt0, cnt1);
      end
      rst = 1'b0; crdy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         pc = 32'(i * 4);
         tick;
      end
      valid = 1'b0;
      tick;
      checks++;
      if ({cnt1, cnt0, v0} !== {4'd1, 32'd17, 1'b0}) begin
         fails++;
         $display("FAIL wrap got cnt1=%0d cnt0=%0d v=%b exp 1 17 0",
                  cnt1, cnt0, v0);
      end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_stall;
      test_mext_illegal;
      test_flush;
      test_reset_wrap;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
